// File: rtl/inst_sequencer_pkg.sv
// ============================================================================
// Module      : inst_sequencer_pkg
// Description : Shared instruction-format constants, opcodes and sequencer
//               state encoding for the instruction sequencer slice.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package inst_sequencer_pkg;

    localparam int INST_W   = 24;
    localparam int LAST_BIT = 31;

    // Instruction field layout: opcode | dst | src1 | src2/imm
    localparam int OPC_MSB  = 23;
    localparam int OPC_LSB  = 18;
    localparam int DST_MSB  = 17;
    localparam int DST_LSB  = 12;
    localparam int SRC1_MSB = 11;
    localparam int SRC1_LSB = 6;
    localparam int SRC2_MSB = 5;
    localparam int SRC2_LSB = 0;

    localparam logic [5:0] NOP    = 6'b000000;
    localparam logic [5:0] ADD    = 6'b000001;
    localparam logic [5:0] SUB    = 6'b000010;
    localparam logic [5:0] MUL_RR = 6'b000011;
    localparam logic [5:0] MUL_RI = 6'b000111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        READY = 2'd2,
        RUN   = 2'd3
    } state_t;

    function automatic logic [5:0] opcode_of(input logic [INST_W-1:0] inst);
        return inst[OPC_MSB:OPC_LSB];
    endfunction

endpackage

`default_nettype wire

// File: rtl/inst_sequencer_if.sv
// ============================================================================
// Module      : inst_sequencer_if
// Description : Host load stream, run control and FU-side instruction bus of
//               the instruction sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface inst_sequencer_if
    import inst_sequencer_pkg::*;
#(
    parameter int ADDR_W = 5
);

    logic              load_valid;
    logic [31:0]       load_data;
    logic              load_ready;
    logic              start;
    logic              stall;
    logic [INST_W-1:0] inst_out;
    logic              inst_valid;
    logic              busy;
    logic              done;
    logic [ADDR_W:0]   prog_len;
    logic              overflow;

    modport master (
        output load_valid, load_data, start, stall,
        input  load_ready, inst_out, inst_valid, busy, done, prog_len, overflow
    );

    modport slave (
        input  load_valid, load_data, start, stall,
        output load_ready, inst_out, inst_valid, busy, done, prog_len, overflow
    );

endinterface

`default_nettype wire

// File: rtl/inst_sequencer_store.sv
// ============================================================================
// Module      : inst_store
// Description : DEPTH x INST_W distributed RAM, synchronous write and
//               asynchronous read.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_store #(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5,
    parameter int INST_W = 24
) (
    input  wire logic              bus_clk,
    input  wire logic              i_we,
    input  wire logic [ADDR_W-1:0] i_waddr,
    input  wire logic [INST_W-1:0] i_wdata,
    input  wire logic [ADDR_W-1:0] i_raddr,
    output logic      [INST_W-1:0] o_rdata
);

    // No reset: contents are meaningless until the sequencer reloads them.
    logic [INST_W-1:0] r_mem [DEPTH];

    always_ff @(posedge bus_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

`default_nettype wire

// File: rtl/inst_sequencer.sv
// ============================================================================
// Module      : inst_sequencer
// Description : Loads a 24-bit program from a 32-bit host stream and replays
//               it to the FU one instruction per cycle, honouring stall.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_sequencer
    import inst_sequencer_pkg::*;
#(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  wire logic         bus_clk,
    input  wire logic         bus_rst_n,
    inst_sequencer_if.slave   bus
);

    state_t              r_state, w_state_nxt;
    logic [ADDR_W-1:0]   r_wp, w_wp_nxt;
    logic [ADDR_W-1:0]   r_rp, w_rp_nxt;
    logic [ADDR_W:0]     r_prog_len, w_prog_len_nxt;
    logic                r_overflow, w_overflow_nxt;
    logic                r_load_ready, w_load_ready_nxt;
    logic [INST_W-1:0]   r_inst_out, w_inst_out_nxt;
    logic                r_inst_valid, w_inst_valid_nxt;
    logic                r_done, w_done_nxt;

    logic [ADDR_W-1:0]   w_waddr;
    logic [ADDR_W-1:0]   w_raddr;
    logic [INST_W-1:0]   w_rdata;
    logic                w_last;
    logic                w_take;
    logic                w_last_inst;
    logic                w_unused_bits;

    assign w_last        = bus.load_data[LAST_BIT];
    assign w_unused_bits = ^bus.load_data[30:24];

    // A load restarts at address 0 unless it is continuing an open LOAD.
    assign w_waddr = (r_state == LOAD) ? r_wp : '0;

    // start wins over a simultaneous word in READY; nothing is written in RUN.
    assign w_take = bus.load_valid && r_load_ready && (r_state != RUN) &&
                    !((r_state == READY) && bus.start);

    // Once an instruction is on the output, look one entry ahead for the next.
    assign w_raddr     = r_inst_valid ? (r_rp + ADDR_W'(1)) : r_rp;
    assign w_last_inst = ({1'b0, r_rp} == (r_prog_len - (ADDR_W+1)'(1)));

    inst_store #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .INST_W (INST_W)
    ) u_store (
        .bus_clk (bus_clk),
        .i_we    (w_take),
        .i_waddr (w_waddr),
        .i_wdata (bus.load_data[INST_W-1:0]),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    always_comb begin
        w_state_nxt      = r_state;
        w_wp_nxt         = r_wp;
        w_rp_nxt         = r_rp;
        w_prog_len_nxt   = r_prog_len;
        w_overflow_nxt   = r_overflow;
        w_load_ready_nxt = r_load_ready;
        w_inst_out_nxt   = r_inst_out;
        w_inst_valid_nxt = r_inst_valid;
        w_done_nxt       = 1'b0;

        case (r_state)
            IDLE, LOAD: begin
                w_load_ready_nxt = 1'b1;
            end
            READY: begin
                if (bus.start) begin
                    w_state_nxt      = RUN;
                    w_rp_nxt         = '0;
                    w_load_ready_nxt = 1'b0;
                    w_inst_out_nxt   = '0;
                    w_inst_valid_nxt = 1'b0;
                end
            end
            RUN: begin
                if (!bus.stall) begin
                    if (!r_inst_valid) begin
                        w_inst_out_nxt   = w_rdata;
                        w_inst_valid_nxt = 1'b1;
                    end else if (w_last_inst) begin
                        w_inst_out_nxt   = '0;
                        w_inst_valid_nxt = 1'b0;
                        w_done_nxt       = 1'b1;
                        w_state_nxt      = READY;
                        w_load_ready_nxt = 1'b1;
                    end else begin
                        w_rp_nxt       = r_rp + ADDR_W'(1);
                        w_inst_out_nxt = w_rdata;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        if (w_take) begin
            if (r_state == READY) begin
                w_overflow_nxt = 1'b0;
            end
            if (w_last) begin
                w_prog_len_nxt = {1'b0, w_waddr} + (ADDR_W+1)'(1);
                w_state_nxt    = READY;
                w_wp_nxt       = '0;
            end else if (w_waddr == ADDR_W'(DEPTH-1)) begin
                // Store full: keep the word, flag truncation, refuse further words.
                w_overflow_nxt   = 1'b1;
                w_prog_len_nxt   = (ADDR_W+1)'(DEPTH);
                w_state_nxt      = READY;
                w_wp_nxt         = '0;
                w_load_ready_nxt = 1'b0;
            end else begin
                w_wp_nxt    = w_waddr + ADDR_W'(1);
                w_state_nxt = LOAD;
            end
        end
    end

    always_ff @(posedge bus_clk or negedge bus_rst_n) begin
        if (!bus_rst_n) begin
            r_state      <= IDLE;
            r_wp         <= '0;
            r_rp         <= '0;
            r_prog_len   <= '0;
            r_overflow   <= 1'b0;
            r_load_ready <= 1'b0;
            r_inst_out   <= '0;
            r_inst_valid <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_wp         <= w_wp_nxt;
            r_rp         <= w_rp_nxt;
            r_prog_len   <= w_prog_len_nxt;
            r_overflow   <= w_overflow_nxt;
            r_load_ready <= w_load_ready_nxt;
            r_inst_out   <= w_inst_out_nxt;
            r_inst_valid <= w_inst_valid_nxt;
            r_done       <= w_done_nxt;
        end
    end

    assign bus.load_ready = r_load_ready;
    assign bus.inst_out   = r_inst_out;
    assign bus.inst_valid = r_inst_valid;
    assign bus.busy       = (r_state == RUN);
    assign bus.done       = r_done;
    assign bus.prog_len   = r_prog_len;
    assign bus.overflow   = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_inst_sequencer.sv
// ============================================================================
// Module      : tb_inst_sequencer
// Description : Directed, table-driven bench for inst_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_inst_sequencer;

    logic bus_clk   = 1'b0;
    logic bus_rst_n = 1'b0;
    int   n_tests   = 0;
    int   n_fail    = 0;

    always #5 bus_clk = ~bus_clk;

    inst_sequencer_if #(.ADDR_W(5)) bus ();

    inst_sequencer #(
        .DEPTH  (32),
        .ADDR_W (5)
    ) dut (
        .bus_clk   (bus_clk),
        .bus_rst_n (bus_rst_n),
        .bus       (bus)
    );

    typedef struct packed {
        logic        start;
        logic        stall;
        logic [23:0] out;
        logic        valid;
        logic        done;
        logic        busy;
    } vec_t;

    vec_t vq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic st, input logic sl, input logic [23:0] o,
                           input logic v, input logic d, input logic b);
        vq.push_back('{start: st, stall: sl, out: o, valid: v, done: d, busy: b});
    endtask

    task automatic send_word(input logic [31:0] w);
        int guard = 0;
        bus.load_valid = 1'b1;
        bus.load_data  = w;
        while (!bus.load_ready && guard < 20) begin
            @(negedge bus_clk);
            guard++;
        end
        if (guard >= 20) begin
            n_tests++;
            n_fail++;
            $display("FAIL load_timeout: got load_ready 0 expected 1");
        end
        @(negedge bus_clk);
        bus.load_valid = 1'b0;
    endtask

    function automatic logic [31:0] ovf_word(input int i);
        return 32'h0004_0000 | (32'(i) << 6) | 32'(i);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   accepted;
        logic low_seen;

        bus.load_valid = 1'b0;
        bus.load_data  = '0;
        bus.start      = 1'b0;
        bus.stall      = 1'b0;

        // Reset values while reset is held
        repeat (2) @(negedge bus_clk);
        check("rst_inst_out",   32'(bus.inst_out),   32'h0);
        check("rst_inst_valid", 32'(bus.inst_valid), 32'h0);
        check("rst_busy",       32'(bus.busy),       32'h0);
        check("rst_done",       32'(bus.done),       32'h0);
        check("rst_overflow",   32'(bus.overflow),   32'h0);
        check("rst_load_ready", 32'(bus.load_ready), 32'h0);
        check("rst_prog_len",   32'(bus.prog_len),   32'h0);
        bus_rst_n = 1'b1;

        // Two-instruction program
        send_word(32'h001D_0003);
        send_word(32'h8005_03CE);
        check("load2_prog_len",   32'(bus.prog_len),   32'd2);
        check("load2_load_ready", 32'(bus.load_ready), 32'h1);
        check("load2_overflow",   32'(bus.overflow),   32'h0);
        check("load2_busy",       32'(bus.busy),       32'h0);

        // Plain run, stalled run, then start held across done
        add_vec(1, 0, 24'h0,      0, 0, 1);
        add_vec(0, 0, 24'h1D0003, 1, 0, 1);
        add_vec(0, 0, 24'h0503CE, 1, 0, 1);
        add_vec(0, 0, 24'h0,      0, 1, 0);
        add_vec(0, 0, 24'h0,      0, 0, 0);
        add_vec(1, 0, 24'h0,      0, 0, 1);
        add_vec(0, 0, 24'h1D0003, 1, 0, 1);
        add_vec(0, 1, 24'h1D0003, 1, 0, 1);
        add_vec(0, 1, 24'h1D0003, 1, 0, 1);
        add_vec(0, 1, 24'h1D0003, 1, 0, 1);
        add_vec(0, 0, 24'h0503CE, 1, 0, 1);
        add_vec(0, 0, 24'h0,      0, 1, 0);
        add_vec(0, 0, 24'h0,      0, 0, 0);
        add_vec(1, 0, 24'h0,      0, 0, 1);
        add_vec(1, 0, 24'h1D0003, 1, 0, 1);
        add_vec(1, 0, 24'h0503CE, 1, 0, 1);
        add_vec(1, 0, 24'h0,      0, 1, 0);
        add_vec(1, 0, 24'h0,      0, 0, 1);
        add_vec(0, 0, 24'h1D0003, 1, 0, 1);
        add_vec(0, 0, 24'h0503CE, 1, 0, 1);
        add_vec(0, 0, 24'h0,      0, 1, 0);
        add_vec(0, 0, 24'h0,      0, 0, 0);

        for (int i = 0; i < vq.size(); i++) begin
            bus.start = vq[i].start;
            bus.stall = vq[i].stall;
            @(negedge bus_clk);
            check($sformatf("vec%0d_inst_out", i), 32'(bus.inst_out),   32'(vq[i].out));
            check($sformatf("vec%0d_valid", i),    32'(bus.inst_valid), 32'(vq[i].valid));
            check($sformatf("vec%0d_done", i),     32'(bus.done),       32'(vq[i].done));
            check($sformatf("vec%0d_busy", i),     32'(bus.busy),       32'(vq[i].busy));
        end
        bus.start = 1'b0;
        bus.stall = 1'b0;

        // start and a load word together in READY: start wins, word dropped
        bus.start      = 1'b1;
        bus.load_valid = 1'b1;
        bus.load_data  = 32'h8000_0001;
        @(negedge bus_clk);
        bus.start      = 1'b0;
        bus.load_valid = 1'b0;
        check("prio_busy",       32'(bus.busy),       32'h1);
        check("prio_load_ready", 32'(bus.load_ready), 32'h0);
        check("prio_prog_len",   32'(bus.prog_len),   32'd2);
        @(negedge bus_clk);
        check("prio_inst0", 32'(bus.inst_out), 32'h1D0003);
        @(negedge bus_clk);
        check("prio_inst1", 32'(bus.inst_out), 32'h0503CE);
        @(negedge bus_clk);
        check("prio_done",  32'(bus.done),     32'h1);

        // 33 words without LAST: only 32 fit
        accepted = 0;
        low_seen = 1'b0;
        bus.load_valid = 1'b1;
        for (int i = 0; i < 33; i++) begin
            bus.load_data = ovf_word(i);
            if (!bus.load_ready) begin
                low_seen = 1'b1;
                break;
            end
            accepted++;
            @(negedge bus_clk);
        end
        bus.load_valid = 1'b0;
        check("ovf_accepted",   32'(accepted),       32'd32);
        check("ovf_ready_low",  32'(low_seen),       32'h1);
        check("ovf_overflow",   32'(bus.overflow),   32'h1);
        check("ovf_prog_len",   32'(bus.prog_len),   32'd32);
        check("ovf_load_ready", 32'(bus.load_ready), 32'h0);

        bus.start = 1'b1;
        @(negedge bus_clk);
        bus.start = 1'b0;
        check("ovf_run_busy",  32'(bus.busy),       32'h1);
        check("ovf_run_valid", 32'(bus.inst_valid), 32'h0);
        for (int k = 0; k < 32; k++) begin
            @(negedge bus_clk);
            check($sformatf("ovf_inst%0d", k), 32'(bus.inst_out), ovf_word(k) & 32'h00FF_FFFF);
            check($sformatf("ovf_valid%0d", k), 32'(bus.inst_valid), 32'h1);
        end
        @(negedge bus_clk);
        check("ovf_done",     32'(bus.done),       32'h1);
        check("ovf_end_valid", 32'(bus.inst_valid), 32'h0);

        // Single-instruction reload clears overflow
        send_word(32'h800C_0041);
        check("one_prog_len", 32'(bus.prog_len), 32'd1);
        check("one_overflow", 32'(bus.overflow), 32'h0);
        bus.start = 1'b1;
        @(negedge bus_clk);
        bus.start = 1'b0;
        @(negedge bus_clk);
        check("one_inst",  32'(bus.inst_out),   32'h0C0041);
        check("one_valid", 32'(bus.inst_valid), 32'h1);
        @(negedge bus_clk);
        check("one_done",  32'(bus.done),       32'h1);
        check("one_out0",  32'(bus.inst_out),   32'h0);

        // Asynchronous reset in the middle of a run
        send_word(32'h0000_0041);
        send_word(32'h0008_1082);
        send_word(32'h800C_30C3);
        check("three_prog_len", 32'(bus.prog_len), 32'd3);
        bus.start = 1'b1;
        @(negedge bus_clk);
        bus.start = 1'b0;
        @(negedge bus_clk);
        check("three_inst0", 32'(bus.inst_out), 32'h000041);
        #2 bus_rst_n = 1'b0;
        #1;
        check("arst_inst_out",   32'(bus.inst_out),   32'h0);
        check("arst_valid",      32'(bus.inst_valid), 32'h0);
        check("arst_busy",       32'(bus.busy),       32'h0);
        check("arst_prog_len",   32'(bus.prog_len),   32'h0);
        check("arst_load_ready", 32'(bus.load_ready), 32'h0);
        @(negedge bus_clk);
        bus_rst_n = 1'b1;
        bus.start = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge bus_clk);
            check($sformatf("post_rst_busy%0d", k),  32'(bus.busy),       32'h0);
            check($sformatf("post_rst_valid%0d", k), 32'(bus.inst_valid), 32'h0);
        end
        bus.start = 1'b0;
        check("post_rst_prog_len", 32'(bus.prog_len), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
